// File: rtl/jtframe_rom_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | jtframe_rom_pkg                                                  |
// | Shared constants for the SDRAM ROM arbiter: FSM encoding,        |
// | priority modes and SDRAM word-address width.                     |
// | Revision: 1.0                                                    |
// +-----------------------------------------------------------------+
package jtframe_rom_pkg;
    localparam int SDRAM_AW = 22;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    localparam logic PRIO_FIXED = 1'b0;
    localparam logic PRIO_RR    = 1'b1;
endpackage
`default_nettype wire

// File: rtl/jtframe_rom_arb_pick.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | jtframe_rom_arb_pick                                             |
// | Combinational picker: fixed or round-robin over the missing      |
// | slots, restricted to the preferred group when it has a miss.     |
// | Revision: 1.0                                                    |
// +-----------------------------------------------------------------+
module jtframe_rom_arb_pick
    import jtframe_rom_pkg::*;
#(
    parameter int SLOTS = 5,
    parameter int IW    = 3
)(
    input  logic [SLOTS-1:0] miss,
    input  logic [SLOTS-1:0] pref,
    input  logic             mode,
    input  logic [IW-1:0]    ptr,
    output logic [SLOTS-1:0] grant,
    output logic [IW-1:0]    idx
);
    logic [SLOTS-1:0] w_pref_miss;
    logic [SLOTS-1:0] w_cand;
    logic             w_found;
    int               w_j;

    assign w_pref_miss = miss & pref;
    assign w_cand      = (|w_pref_miss) ? w_pref_miss : miss;

    // Round-robin scans starting one past the last served slot.
    always_comb begin
        grant   = '0;
        idx     = '0;
        w_found = 1'b0;
        w_j     = 0;
        for (int k = 0; k < SLOTS; k++) begin
            if (mode == PRIO_RR)
                w_j = (int'(ptr) + 1 + k) % SLOTS;
            else
                w_j = k;
            if (!w_found && w_cand[w_j]) begin
                w_found    = 1'b1;
                grant[w_j] = 1'b1;
                idx        = IW'(w_j);
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/jtframe_rom_arb.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | jtframe_rom_arb                                                  |
// | N-slot SDRAM ROM arbiter with a one-entry 32-bit cache per slot. |
// | Revision: 1.0                                                    |
// +-----------------------------------------------------------------+
module jtframe_rom_arb
    import jtframe_rom_pkg::*;
#(
    parameter int                       SLOTS      = 5,
    parameter int                       AW         = 18,
    parameter logic [SDRAM_AW*SLOTS-1:0] OFFSETS   = '0,
    parameter int                       PRIO_MODE  = 0,
    parameter logic [SLOTS-1:0]         VIDEO_MASK = SLOTS'(5'b10000)
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SLOTS-1:0]       slot_cs,
    input  logic [SLOTS*AW-1:0]    slot_addr,
    output logic [SLOTS*32-1:0]    slot_dout,
    output logic [SLOTS-1:0]       slot_ok,
    input  logic                   vblank,
    input  logic                   downloading,
    input  logic                   loop_rst,
    output logic                   sdram_req,
    input  logic                   sdram_ack,
    input  logic                   data_rdy,
    output logic [SDRAM_AW-1:0]    sdram_addr,
    input  logic [31:0]            data_read,
    output logic                   refresh_en
);
    localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int TW = AW - 1;

    logic [1:0]          r_state;
    logic                r_req;
    logic [SDRAM_AW-1:0] r_addr;
    logic [IW-1:0]       r_sel;
    logic [IW-1:0]       r_ptr;
    logic [TW-1:0]       r_tag_lat;

    logic                r_valid [SLOTS];
    logic [TW-1:0]       r_tag   [SLOTS];
    logic [31:0]         r_dout  [SLOTS];

    logic [SLOTS-1:0]    w_miss;
    logic [SLOTS-1:0]    w_req_miss;
    logic [SLOTS-1:0]    w_pref;
    logic [SLOTS-1:0]    w_grant;
    logic [IW-1:0]       w_idx;
    logic                w_any;
    logic                w_fill;
    logic [AW-1:0]       w_gaddr;
    logic [SDRAM_AW-1:0] w_goff;
    logic [SDRAM_AW-1:0] w_new_addr;

    generate
        for (genvar i = 0; i < SLOTS; i++) begin : g_slot
            logic [AW-1:0] w_a;
            assign w_a                   = slot_addr[AW*i +: AW];
            assign slot_ok[i]            = slot_cs[i] & r_valid[i] & (r_tag[i] == w_a[AW-1:1]);
            assign slot_dout[32*i +: 32] = r_dout[i];

            // Invalidation wins over a same-cycle fill, so a download never leaves stale valid bits.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_valid[i] <= 1'b0;
                    r_tag[i]   <= '0;
                    r_dout[i]  <= '0;
                end else begin
                    if (w_fill && r_sel == IW'(i)) begin
                        r_valid[i] <= 1'b1;
                        r_tag[i]   <= r_tag_lat;
                        r_dout[i]  <= data_read;
                    end
                    if (downloading || loop_rst)
                        r_valid[i] <= 1'b0;
                end
            end
        end
    endgenerate

    assign w_miss     = slot_cs & ~slot_ok;
    assign w_req_miss = downloading ? '0 : w_miss;
    assign w_pref     = vblank ? ~VIDEO_MASK : VIDEO_MASK;
    assign w_any      = |w_grant;
    assign w_fill     = (r_state == WAIT) && data_rdy;

    jtframe_rom_arb_pick #(
        .SLOTS (SLOTS),
        .IW    (IW)
    ) u_pick (
        .miss  (w_req_miss),
        .pref  (w_pref),
        .mode  ((PRIO_MODE == 1) ? PRIO_RR : PRIO_FIXED),
        .ptr   (r_ptr),
        .grant (w_grant),
        .idx   (w_idx)
    );

    assign w_gaddr    = slot_addr[AW*w_idx +: AW];
    assign w_goff     = OFFSETS[SDRAM_AW*w_idx +: SDRAM_AW];
    assign w_new_addr = w_goff + SDRAM_AW'(w_gaddr & ~AW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_req     <= 1'b0;
            r_addr    <= '0;
            r_sel     <= '0;
            r_tag_lat <= '0;
            r_ptr     <= IW'(SLOTS - 1);
        end else begin
            case (r_state)
                IDLE: if (w_any) begin
                    r_sel     <= w_idx;
                    r_tag_lat <= w_gaddr[AW-1:1];
                    r_addr    <= w_new_addr;
                    r_ptr     <= w_idx;
                    r_req     <= 1'b1;
                    r_state   <= REQ;
                end
                REQ: if (sdram_ack) begin
                    r_req   <= 1'b0;
                    r_state <= WAIT;
                end
                WAIT: if (data_rdy)
                    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign sdram_req  = r_req;
    assign sdram_addr = r_addr;
    assign refresh_en = (r_state == IDLE) && !(|w_req_miss);
endmodule
`default_nettype wire

// File: tb/tb_jtframe_rom_arb.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_jtframe_rom_arb                                               |
// | Directed bench: a fixed-priority and a round-robin arbiter.      |
// | Revision: 1.0                                                    |
// +-----------------------------------------------------------------+
module tb_jtframe_rom_arb;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [4:0]   cs_f = '0, cs_r = '0;
    logic [89:0]  slot_addr = '0;
    logic         vblank = 1'b0, downloading = 1'b0, loop_rst = 1'b0;
    logic         ack_f = 1'b0, rdy_f = 1'b0, ack_r = 1'b0, rdy_r = 1'b0;
    logic [31:0]  data_read = '0;

    logic [159:0] dout_f, dout_r;
    logic [4:0]   ok_f, ok_r;
    logic         req_f, req_r, ref_f, ref_r;
    logic [21:0]  saddr_f, saddr_r;

    int checks = 0;
    int failures = 0;
    logic [21:0] a;

    always #5 clk = ~clk;

    jtframe_rom_arb #(
        .SLOTS(5), .AW(18),
        .OFFSETS({22'd0, 22'd0, 22'd0, 22'h14000, 22'd0}),
        .PRIO_MODE(0), .VIDEO_MASK(5'b10000)
    ) u_fix (
        .clk(clk), .rst(rst), .slot_cs(cs_f), .slot_addr(slot_addr),
        .slot_dout(dout_f), .slot_ok(ok_f), .vblank(vblank),
        .downloading(downloading), .loop_rst(loop_rst),
        .sdram_req(req_f), .sdram_ack(ack_f), .data_rdy(rdy_f),
        .sdram_addr(saddr_f), .data_read(data_read), .refresh_en(ref_f)
    );

    jtframe_rom_arb #(
        .SLOTS(5), .AW(18), .OFFSETS('0),
        .PRIO_MODE(1), .VIDEO_MASK(5'b10000)
    ) u_rr (
        .clk(clk), .rst(rst), .slot_cs(cs_r), .slot_addr(slot_addr),
        .slot_dout(dout_r), .slot_ok(ok_r), .vblank(vblank),
        .downloading(downloading), .loop_rst(loop_rst),
        .sdram_req(req_r), .sdram_ack(ack_r), .data_rdy(rdy_r),
        .sdram_addr(saddr_r), .data_read(data_read), .refresh_en(ref_r)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int k, input logic [17:0] v);
        slot_addr[18*k +: 18] = v;
    endtask

    // Bounded SDRAM-controller handshake; returns the address requested.
    task automatic serve(input bit rr, input logic [31:0] dat, output logic [21:0] addr);
        int n = 0;
        while (!(rr ? req_r : req_f) && n < 10) begin
            tick();
            n++;
        end
        check("req_seen", 64'(rr ? req_r : req_f), 64'd1);
        addr = rr ? saddr_r : saddr_f;
        if (rr) ack_r = 1'b1; else ack_f = 1'b1;
        tick();
        ack_r = 1'b0; ack_f = 1'b0;
        tick();
        data_read = dat;
        if (rr) rdy_r = 1'b1; else rdy_f = 1'b1;
        tick();
        rdy_r = 1'b0; rdy_f = 1'b0;
    endtask

    initial begin
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_ok",    64'(ok_f),    64'd0);
        check("rst_req",   64'(req_f),   64'd0);
        check("rst_addr",  64'(saddr_f), 64'd0);
        check("rst_ref",   64'(ref_f),   64'd1);
        check("rst_dout",  64'(dout_f[63:32]), 64'd0);

        // Single miss on slot 1 with offset
        set_addr(1, 18'h4); cs_f = 5'b00010;
        #1;
        check("miss_ok0",  64'(ok_f[1]), 64'd0);
        check("miss_ref",  64'(ref_f),   64'd0);
        check("miss_req0", 64'(req_f),   64'd0);
        tick();
        check("miss_req1", 64'(req_f),   64'd1);
        check("miss_addr", 64'(saddr_f), 64'h14004);
        ack_f = 1'b1; tick(); ack_f = 1'b0;
        check("ack_drop",  64'(req_f),   64'd0);
        data_read = 32'hDEADBEEF; rdy_f = 1'b1; tick(); rdy_f = 1'b0;
        check("fill_ok",   64'(ok_f[1]), 64'd1);
        check("fill_dout", 64'(dout_f[63:32]), 64'hDEADBEEF);
        set_addr(1, 18'h5);
        #1;
        check("hit_ok",    64'(ok_f[1]), 64'd1);
        tick();
        check("hit_noreq", 64'(req_f),   64'd0);
        data_read = 32'hCAFEF00D; rdy_f = 1'b1; tick(); rdy_f = 1'b0;
        check("idle_rdy",  64'(dout_f[63:32]), 64'hDEADBEEF);

        // Fixed priority order
        vblank = 1'b1;
        set_addr(0, 18'h100); set_addr(2, 18'h200); set_addr(3, 18'h300);
        cs_f = 5'b01101;
        serve(1'b0, 32'h0, a); check("fix_1st", 64'(a), 64'h100);
        serve(1'b0, 32'h2, a); check("fix_2nd", 64'(a), 64'h200);
        serve(1'b0, 32'h3, a); check("fix_3rd", 64'(a), 64'h300);
        check("fix_ok", 64'(ok_f), 64'b01101);

        // Video-phase priority swap
        vblank = 1'b0;
        set_addr(0, 18'h400); set_addr(4, 18'h480); cs_f = 5'b10001;
        serve(1'b0, 32'h0, a); check("vid0_1st", 64'(a), 64'h480);
        serve(1'b0, 32'h0, a); check("vid0_2nd", 64'(a), 64'h400);
        vblank = 1'b1;
        set_addr(0, 18'h500); set_addr(4, 18'h580);
        serve(1'b0, 32'h0, a); check("vid1_1st", 64'(a), 64'h500);
        serve(1'b0, 32'h0, a); check("vid1_2nd", 64'(a), 64'h580);

        // Address change while waiting for data
        cs_f = 5'b00001; set_addr(0, 18'h10);
        tick();
        check("aw_req",  64'(req_f),   64'd1);
        check("aw_addr", 64'(saddr_f), 64'h10);
        ack_f = 1'b1; tick(); ack_f = 1'b0;
        set_addr(0, 18'h20);
        tick();
        data_read = 32'h11111111; rdy_f = 1'b1; tick(); rdy_f = 1'b0;
        check("aw_ok_new", 64'(ok_f[0]), 64'd0);
        set_addr(0, 18'h11);
        #1;
        check("aw_tag8",   64'(ok_f[0]), 64'd1);
        tick();
        check("aw_noreq",  64'(req_f),   64'd0);
        set_addr(0, 18'h20);
        serve(1'b0, 32'h22222222, a);
        check("aw_readdr", 64'(a), 64'h20);
        check("aw_dout",   64'(dout_f[31:0]), 64'h22222222);

        // Fill all, then invalidate
        for (int k = 0; k < 5; k++) set_addr(k, 18'(18'h600 + 18'h10 * k));
        cs_f = 5'b11111;
        for (int k = 0; k < 5; k++) serve(1'b0, 32'(k), a);
        check("all_ok", 64'(ok_f), 64'b11111);
        loop_rst = 1'b1;
        #1;
        check("lr_same", 64'(ok_f), 64'b11111);
        tick();
        loop_rst = 1'b0; downloading = 1'b1;
        #1;
        check("lr_ok",  64'(ok_f),  64'd0);
        check("dl_ref", 64'(ref_f), 64'd1);
        tick();
        check("dl_req1", 64'(req_f), 64'd0);
        tick();
        check("dl_req2", 64'(req_f), 64'd0);
        downloading = 1'b0;
        tick();
        check("rereq", 64'(req_f), 64'd1);

        // Reset during REQ
        rst = 1'b1;
        tick();
        check("rstm_req", 64'(req_f), 64'd0);
        check("rstm_ok",  64'(ok_f),  64'd0);
        cs_f = '0; rst = 1'b0;
        #1;
        check("rstm_idle", 64'(ref_f), 64'd1);

        // Round-robin: prime pointer at slot 2, then 0,2,3 all miss
        vblank = 1'b1;
        set_addr(2, 18'h200); cs_r = 5'b00100;
        serve(1'b1, 32'h0, a); check("rr_prime", 64'(a), 64'h200);
        set_addr(0, 18'h100); set_addr(2, 18'h240); set_addr(3, 18'h300);
        cs_r = 5'b01101;
        serve(1'b1, 32'h0, a); check("rr_1st", 64'(a), 64'h300);
        serve(1'b1, 32'h0, a); check("rr_2nd", 64'(a), 64'h100);
        serve(1'b1, 32'h0, a); check("rr_3rd", 64'(a), 64'h240);
        check("rr_ok", 64'(ok_r), 64'b01101);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
